// File: rtl/vga_scan_timing.sv
// 640x480@60 raster timing: 25 MHz pixel enable, stage-0 counters and stage-1 registered colour/sync/blank.
// Define FRAME_TICK_EN to build the once-per-frame game-logic tick; otherwise frame_tick is tied low.
module vga_scan_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  Red,
    input  logic [7:0]  Green,
    input  logic [7:0]  Blue,
    output logic [10:0] DrawX,
    output logic [10:0] DrawY,
    output logic        VGA_CLK,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic        pix_en;
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        line_end;
    logic        visible;
    logic        hs_next;
    logic        vs_next;
    logic [7:0]  r_next;
    logic [7:0]  g_next;
    logic [7:0]  b_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        line_end = 1'b0;
        h_next   = h_cnt + 11'd1;
        v_next   = v_cnt;
        if (h_cnt == H_LAST) begin
            line_end = 1'b1;
            h_next   = '0;
            v_next   = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // Stage-1 inputs are decoded from the current stage-0 position, so outputs trail DrawX/DrawY by one pixel.
    always_comb begin
        visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_next = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
        vs_next = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
        r_next  = '0;
        g_next  = '0;
        b_next  = '0;
        if (visible) begin
            r_next = Red;
            g_next = Green;
            b_next = Blue;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
        end else if (pix_en) begin
            VGA_R       <= r_next;
            VGA_G       <= g_next;
            VGA_B       <= b_next;
            VGA_HS      <= hs_next;
            VGA_VS      <= vs_next;
            VGA_BLANK_N <= visible;
        end
    end

`ifdef FRAME_TICK_EN
    localparam logic [10:0] V_VIS_LAST = 11'(V_VISIBLE - 1);

    // Fires on the edge that moves stage 0 from the last visible line into vertical blank.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= pix_en && line_end && (v_cnt == V_VIS_LAST);
        end
    end
`else
    assign frame_tick = 1'b0;
`endif

    assign DrawX      = h_cnt;
    assign DrawY      = v_cnt;
    assign VGA_CLK    = pix_en;
    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Scoreboard bench for vga_scan_timing on a reduced raster so whole frames fit a short run.
module tb_vga_scan_timing;

    localparam int HV = 64, HF = 4, HS = 8, HB = 6;
    localparam int VV = 20, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CLK = 2 * HT * VT;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  Red = '0, Green = '0, Blue = '0;
    logic [10:0] DrawX, DrawY;
    logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_tick;
    logic [7:0]  VGA_R, VGA_G, VGA_B;

    vga_scan_timing #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Red(Red), .Green(Green), .Blue(Blue),
        .DrawX(DrawX), .DrawY(DrawY), .VGA_CLK(VGA_CLK),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N), .frame_tick(frame_tick)
    );

    always #10 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       blank_n;
    } stage1_t;

    stage1_t sb_q[$];
    stage1_t cur;
    int      checks = 0;
    int      errors = 0;
    int      mx, my;
    logic    m_pix;
    logic    exp_tick;
    bit      all_ff = 0;
    bit      counting = 0;
    int      step_idx = 0;
    int      last_tick = -1;
    int      hs_run, vs_run;
    int      hs_low_clk, vs_low_clk, blank_clk, tick_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic stage1_t model_out(input int x, input int y,
                                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        stage1_t o;
        logic vis;
        vis       = (x < HV) && (y < VV);
        o.hs      = !((x >= HV + HF) && (x < HV + HF + HS));
        o.vs      = !((y >= VV + VF) && (y < VV + VF + VS));
        o.blank_n = vis;
        o.r       = vis ? r : 8'h00;
        o.g       = vis ? g : 8'h00;
        o.b       = vis ? b : 8'h00;
        return o;
    endfunction

    task automatic model_reset();
        mx       = 0;
        my       = 0;
        m_pix    = 1'b0;
        exp_tick = 1'b0;
        hs_run   = 0;
        vs_run   = 0;
        sb_q.delete();
        cur = '{r: 8'h00, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1, blank_n: 1'b0};
    endtask

    // One Clk cycle: drive inputs, push the expected stage-1 word on pixel edges, then compare at the falling edge.
    task automatic step();
        logic    sample;
        stage1_t e;
        logic [7:0] exp_r;
        sample = m_pix;
        if (sample) begin
            if (all_ff) begin
                Red = 8'hFF; Green = 8'hFF; Blue = 8'hFF;
                exp_r = 8'hFF;
            end else begin
                Red = DrawX[7:0]; Green = 8'hFF; Blue = 8'($urandom);
                exp_r = 8'(mx);
            end
            e = model_out(mx, my, exp_r, Green, Blue);
            sb_q.push_back(e);
            exp_tick = (mx == HT - 1) && (my == VV - 1);
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end else begin
            // Junk between pixel edges must never reach the outputs.
            Red = 8'($urandom); Green = 8'($urandom); Blue = 8'($urandom);
            exp_tick = 1'b0;
        end
        m_pix = !m_pix;
        @(posedge Clk);
        @(negedge Clk);
        step_idx++;
        if (sample) begin
            if (sb_q.size() == 0) check("sb_underflow", 1, 0);
            else cur = sb_q.pop_front();
        end
        check("draw_x", DrawX, mx);
        check("draw_y", DrawY, my);
        check("vga_clk", VGA_CLK, m_pix);
        check("sync_n", VGA_SYNC_N, 0);
`ifdef FRAME_TICK_EN
        check("frame_tick", frame_tick, exp_tick);
`else
        check("frame_tick", frame_tick, 0);
`endif
        check("vga_r", VGA_R, cur.r);
        check("vga_g", VGA_G, cur.g);
        check("vga_b", VGA_B, cur.b);
        check("vga_hs", VGA_HS, cur.hs);
        check("vga_vs", VGA_VS, cur.vs);
        check("blank_n", VGA_BLANK_N, cur.blank_n);

        hs_low_clk += (VGA_HS === 1'b0) ? 1 : 0;
        vs_low_clk += (VGA_VS === 1'b0) ? 1 : 0;
        blank_clk  += (VGA_BLANK_N === 1'b1) ? 1 : 0;
        tick_cnt   += (frame_tick === 1'b1) ? 1 : 0;
        if (VGA_HS === 1'b0) hs_run++;
        else if (hs_run > 0) begin
            if (counting) check("hs_width_clk", hs_run, 2 * HS);
            hs_run = 0;
        end
        if (VGA_VS === 1'b0) vs_run++;
        else if (vs_run > 0) begin
            if (counting) check("vs_width_clk", vs_run, 2 * VS * HT);
            vs_run = 0;
        end
        if (frame_tick === 1'b1) begin
            if (counting && last_tick >= 0) check("tick_period", step_idx - last_tick, FRAME_CLK);
            last_tick = step_idx;
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_draw_x"}, DrawX, 0);
        check({pfx, "_draw_y"}, DrawY, 0);
        check({pfx, "_vga_clk"}, VGA_CLK, 0);
        check({pfx, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 0);
        check({pfx, "_hs"}, VGA_HS, 1);
        check({pfx, "_vs"}, VGA_VS, 1);
        check({pfx, "_blank_n"}, VGA_BLANK_N, 0);
        check({pfx, "_frame_tick"}, frame_tick, 0);
    endtask

    initial begin
        bit reached;
        model_reset();
        hs_low_clk = 0; vs_low_clk = 0; blank_clk = 0; tick_cnt = 0;
        repeat (3) @(negedge Clk);
        check_reset_values("por");
        Reset = 1'b0;

        // Run through a line wrap into the middle of a line, then reset asynchronously mid-frame.
        reached = 0;
        for (int i = 0; i < FRAME_CLK && !reached; i++) begin
            step();
            if (mx == 30 && my == 10 && m_pix == 1'b0) reached = 1;
        end
        check("reach_mid_frame", reached, 1);
        #3 Reset = 1'b1;
        #1 check_reset_values("mid_rst");
        @(negedge Clk);
        check_reset_values("mid_rst_held");
        Reset = 1'b0;
        model_reset();
        step();
        check("post_rst_e1_x", DrawX, 0);
        step();
        check("post_rst_e2_x", DrawX, 1);
        check("post_rst_e2_y", DrawY, 0);

        // Two full frames with totals; the second holds full-white colour to exercise blanking.
        repeat (10) step();
        counting = 1;
        for (int f = 0; f < 2; f++) begin
            hs_low_clk = 0; vs_low_clk = 0; blank_clk = 0; tick_cnt = 0;
            all_ff = (f == 1);
            repeat (FRAME_CLK) step();
            check("hs_low_total", hs_low_clk, 2 * HS * VT);
            check("vs_low_total", vs_low_clk, 2 * VS * HT);
            check("blank_n_total", blank_clk, 2 * HV * VV);
`ifdef FRAME_TICK_EN
            check("ticks_per_frame", tick_cnt, 1);
`else
            check("ticks_per_frame", tick_cnt, 0);
`endif
        end
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
